cart_bus_ctrl: RTL and testbench
================================

// Module: cart_bus_ctrl
//
// PURPOSE
//   Parametrised Game Boy cartridge bus controller, clocked at 8 MHz, between the CPU
//   memory arbiter and the cartridge edge connector.
//   - Runs one /CS-framed read or write per request. Setup, strobe and hold times are
//     programmable per parameter.
//   - Pulses ack when the access completes.
//   - Generates the cartridge PHI clock.
//
// PARAMETERS
//   AW           16  address width (cart_a, addr)
//   DW            8  data width (din, dout, cart_d_*)
//   T_SETUP       1  clk_8m cycles: /CS (and /RD for reads) low before the strobe phase; >=1
//   T_STROBE      2  cycles of strobe phase: /WR low on writes, data settling on reads; >=1
//   T_HOLD        1  cycles /CS stays low after the strobe phase; >=1
//   CLKDIV_LOG2   3  cart_clk = clk_8m / 2^CLKDIV_LOG2 (3 -> 1 MHz); >=1
//
// PORTS
//   clk_8m       in   1   system clock, 8 MHz
//   rst          in   1   synchronous reset, active-high
//   req_rd       in   1   read request, sampled only in IDLE
//   req_wr       in   1   write request, sampled only in IDLE
//   addr         in   AW  request address, latched on accept
//   din          in   DW  write data, latched on accept
//   dout         out  DW  read data, register
//   ack          out  1   one-cycle pulse when an access completes
//   busy         out  1   (state!=IDLE) | req_rd | req_wr
//   cart_a       out  AW  latched address to the cart
//   cart_d_in    in   DW  cart data bus input
//   cart_d_out   out  DW  cart data bus output (last written value)
//   cart_ncs     out  1   cart /CS, active-low
//   cart_nrd     out  1   cart /RD, active-low
//   cart_nwr     out  1   cart /WR, active-low
//   cart_clk     out  1   cart PHI clock
//   cart_busdir  out  1   ~cart_nrd (level shifter direction; 1 = cart drives bus)
//
// BEHAVIOUR
//   - Reset values: dout all-ones; cart_a=0; cart_d_out=0; ncs/nrd/nwr=1; ack=0;
//     state=IDLE; clock divider=0.
//   - FSM states: IDLE -> SETUP -> STROBE -> HOLD -> IDLE. Phase length is counted by one
//     down-counter sized $clog2(max(T_*)+1).
//   - Accept: at the edge where state==IDLE and (req_rd|req_wr).
//     - Latch addr->cart_a. Drive ncs=0.
//     - Read: nrd=0.
//     - Write: din->cart_d_out, nrd stays 1.
//     - If req_rd and req_wr are both high, the read wins. The write is dropped with no ack.
//   - Cycle k = k-th cycle after the accept edge. Let N = T_SETUP+T_STROBE+T_HOLD.
//     - SETUP: cycles 1..T_SETUP.
//     - STROBE: next T_STROBE cycles. Writes: nwr=0 for exactly T_STROBE cycles.
//     - HOLD: next T_HOLD cycles. nwr=1; ncs still 0.
//     - Read data: cart_d_in -> dout at the edge ending the last STROBE cycle. dout holds
//       until the next read completes; writes never change dout.
//     - At the edge ending HOLD: ncs=1, nrd=1, ack=1 for cycle N+1 only, state=IDLE.
//   - ncs is low for exactly N cycles. nrd tracks ncs on reads.
//   - A new request may be accepted in the ack cycle (back-to-back). /CS is then high for
//     exactly 1 cycle between accesses.
//   - Requests present outside IDLE are ignored. Callers hold a request until ack or
//     re-issue it; busy tells them the bus is occupied.
//   - Reset mid-access: next edge returns all outputs to reset values; no ack.
//   - cart_clk = divider MSB; the divider increments every cycle and wraps modulo
//     2^CLKDIV_LOG2.
//
// CONFIGURATION
//   CART_CLK_SYNC_EN
//     - Defined: the divider is forced to 0 on the accept edge, so cart_clk is 0 at cycle 1
//       and rises 2^(CLKDIV_LOG2-1) cycles after accept, aligned to the access.
//     - Undefined: the divider free-runs; accesses ignore it.
//
// TESTING
//   1. Default params, req_rd=1 for 1 cycle, addr=0x4000, cart_d_in=0x5A:
//      ncs/nrd low for cycles 1-4; ack in cycle 5; dout=0x5A; nwr never low.
//   2. Write addr=0x2000, din=0x03: cart_a=0x2000, cart_d_out=0x03; nwr low in cycles 2-3
//      only; ncs low in cycles 1-4; ack in cycle 5; dout unchanged.
//   3. req_rd=req_wr=1, addr=0x0100: read performed (nwr stays 1); exactly one ack.
//   4. rst asserted in cycle 2 of a write: next edge ncs=nwr=1, dout=0xFF; no ack;
//      FSM accepts a new read right after rst drops.
//   5. T_STROBE=4, T_HOLD=2, back-to-back reads: ncs low for 7 cycles, high for 1 cycle,
//      then low again; ack in cycle 8.
//   6. With CART_CLK_SYNC_EN, CLKDIV_LOG2=3: cart_clk=0 in cycles 1-4 and 1 in cycles 5-8
//      after every accept. Without the macro: period 8, 50% duty, independent of requests.

Source files
------------

// File: rtl/cart_bus_ctrl_if.sv
// Request-side bus between the CPU memory arbiter (master) and the cartridge bus controller (slave).
// The arbiter raises req_rd/req_wr with addr/din; the controller answers with dout, a one-cycle ack and busy.
interface cart_bus_ctrl_if #(
    parameter int AW = 16,
    parameter int DW = 8
);
    logic          req_rd;
    logic          req_wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] din;
    logic [DW-1:0] dout;
    logic          ack;
    logic          busy;

    modport master (
        output req_rd, req_wr, addr, din,
        input  dout, ack, busy
    );

    modport slave (
        input  req_rd, req_wr, addr, din,
        output dout, ack, busy
    );
endinterface

// File: rtl/cart_bus_ctrl.sv
// Game Boy cartridge bus controller: one /CS-framed read or write per request, plus cart PHI clock.
// Latency: /CS low T_SETUP+T_STROBE+T_HOLD cycles after accept, ack in the following cycle.
// Backpressure: requests are sampled only in IDLE; busy flags an occupied bus. CART_CLK_SYNC_EN aligns PHI to accepts.
module cart_bus_ctrl #(
    parameter int AW          = 16,
    parameter int DW          = 8,
    parameter int T_SETUP     = 1,
    parameter int T_STROBE    = 2,
    parameter int T_HOLD      = 1,
    parameter int CLKDIV_LOG2 = 3
) (
    input  logic          clk_8m,
    input  logic          rst,
    cart_bus_ctrl_if.slave bus,
    output logic [AW-1:0] cart_a,
    input  logic [DW-1:0] cart_d_in,
    output logic [DW-1:0] cart_d_out,
    output logic          cart_ncs,
    output logic          cart_nrd,
    output logic          cart_nwr,
    output logic          cart_clk,
    output logic          cart_busdir
);
    localparam int T_SS  = (T_SETUP > T_STROBE) ? T_SETUP : T_STROBE;
    localparam int T_MAX = (T_SS > T_HOLD) ? T_SS : T_HOLD;
    localparam int CW    = $clog2(T_MAX + 1);

    // Counter reloads are phase length minus one: the reload edge itself starts the first cycle.
    localparam logic [CW-1:0] C_SETUP  = CW'(T_SETUP - 1);
    localparam logic [CW-1:0] C_STROBE = CW'(T_STROBE - 1);
    localparam logic [CW-1:0] C_HOLD   = CW'(T_HOLD - 1);

    typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

    state_t                 state;
    logic [CW-1:0]          cnt;
    logic                   is_rd;
    logic [CLKDIV_LOG2-1:0] div;
    logic [DW-1:0]          dout_q;
    logic                   ack_q;

    always_ff @(posedge clk_8m) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            is_rd      <= 1'b0;
            div        <= '0;
            dout_q     <= '1;
            ack_q      <= 1'b0;
            cart_a     <= '0;
            cart_d_out <= '0;
            cart_ncs   <= 1'b1;
            cart_nrd   <= 1'b1;
            cart_nwr   <= 1'b1;
        end else begin
            ack_q <= 1'b0;
            div   <= div + 1'b1;
            case (state)
                IDLE: begin
                    if (bus.req_rd || bus.req_wr) begin
                        state    <= SETUP;
                        cnt      <= C_SETUP;
                        cart_a   <= bus.addr;
                        cart_ncs <= 1'b0;
                        is_rd    <= bus.req_rd;
                        // A simultaneous write request is dropped in favour of the read.
                        if (bus.req_rd) begin
                            cart_nrd <= 1'b0;
                        end else begin
                            cart_d_out <= bus.din;
                        end
`ifdef CART_CLK_SYNC_EN
                        div <= '0;
`endif
                    end
                end
                SETUP: begin
                    if (cnt == '0) begin
                        state    <= STROBE;
                        cnt      <= C_STROBE;
                        cart_nwr <= is_rd;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                STROBE: begin
                    if (cnt == '0) begin
                        state    <= HOLD;
                        cnt      <= C_HOLD;
                        cart_nwr <= 1'b1;
                        if (is_rd) begin
                            dout_q <= cart_d_in;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                HOLD: begin
                    if (cnt == '0) begin
                        state    <= IDLE;
                        cart_ncs <= 1'b1;
                        cart_nrd <= 1'b1;
                        ack_q    <= 1'b1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.dout    = dout_q;
    assign bus.ack     = ack_q;
    assign bus.busy    = (state != IDLE) || bus.req_rd || bus.req_wr;
    assign cart_clk    = div[CLKDIV_LOG2-1];
    assign cart_busdir = ~cart_nrd;
endmodule

// File: tb/tb_cart_bus_ctrl.sv
// Bench for cart_bus_ctrl: DUT0 default timing, DUT1 with T_STROBE=4/T_HOLD=2, both against a phase-index model.
module tb_cart_bus_ctrl;
    logic clk_8m = 1'b0;
    logic rst    = 1'b1;
    always #5 clk_8m = ~clk_8m;

    logic        req_rd [2];
    logic        req_wr [2];
    logic [15:0] addr   [2];
    logic [7:0]  din    [2];
    logic [7:0]  cart_d_in [2];
    logic [7:0]  dout   [2];
    logic        ack    [2];
    logic        busy   [2];
    logic [15:0] cart_a [2];
    logic [7:0]  cart_d_out [2];
    logic        ncs [2], nrd [2], nwr [2], cclk [2], bdir [2];

    int checks = 0;
    int errors = 0;

    cart_bus_ctrl_if #(.AW(16), .DW(8)) bus0 ();
    cart_bus_ctrl_if #(.AW(16), .DW(8)) bus1 ();

    assign bus0.req_rd = req_rd[0];
    assign bus0.req_wr = req_wr[0];
    assign bus0.addr   = addr[0];
    assign bus0.din    = din[0];
    assign dout[0]     = bus0.dout;
    assign ack[0]      = bus0.ack;
    assign busy[0]     = bus0.busy;
    assign bus1.req_rd = req_rd[1];
    assign bus1.req_wr = req_wr[1];
    assign bus1.addr   = addr[1];
    assign bus1.din    = din[1];
    assign dout[1]     = bus1.dout;
    assign ack[1]      = bus1.ack;
    assign busy[1]     = bus1.busy;

    cart_bus_ctrl dut0 (
        .clk_8m(clk_8m), .rst(rst), .bus(bus0),
        .cart_a(cart_a[0]), .cart_d_in(cart_d_in[0]), .cart_d_out(cart_d_out[0]),
        .cart_ncs(ncs[0]), .cart_nrd(nrd[0]), .cart_nwr(nwr[0]),
        .cart_clk(cclk[0]), .cart_busdir(bdir[0])
    );

    cart_bus_ctrl #(.T_STROBE(4), .T_HOLD(2)) dut1 (
        .clk_8m(clk_8m), .rst(rst), .bus(bus1),
        .cart_a(cart_a[1]), .cart_d_in(cart_d_in[1]), .cart_d_out(cart_d_out[1]),
        .cart_ncs(ncs[1]), .cart_nrd(nrd[1]), .cart_nwr(nwr[1]),
        .cart_clk(cclk[1]), .cart_busdir(bdir[1])
    );

    task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d actual=%0h required=%0h t=%0t", nm, i, act, exp, $time);
        end
    endtask

    // Model: k = cycles since accept (0 = idle), outputs follow from k and the phase lengths.
    function automatic int f_ts(input int i); return 1; endfunction
    function automatic int f_tt(input int i); return (i == 0) ? 2 : 4; endfunction
    function automatic int f_th(input int i); return (i == 0) ? 1 : 2; endfunction
    function automatic int f_n(input int i);  return f_ts(i) + f_tt(i) + f_th(i); endfunction

    int          k [2];
    bit          op_rd [2];
    logic [15:0] m_a [2];
    logic [7:0]  m_dout [2];
    logic [7:0]  m_dw [2];
    int          m_div [2];
    bit          m_valid = 1'b0;

    function automatic bit f_acc(input int i);
        return (k[i] >= 1) && (k[i] <= f_n(i));
    endfunction

    function automatic bit f_wr_strobe(input int i);
        return f_acc(i) && !op_rd[i] && (k[i] > f_ts(i)) && (k[i] <= f_ts(i) + f_tt(i));
    endfunction

    always @(posedge clk_8m) begin
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                k[i] <= 0; op_rd[i] <= 1'b0; m_a[i] <= '0; m_dw[i] <= '0;
                m_dout[i] <= 8'hFF; m_div[i] <= 0;
            end else begin
                m_div[i] <= (m_div[i] + 1) % 8;
                if (f_acc(i)) begin
                    if (op_rd[i] && k[i] == f_ts(i) + f_tt(i)) m_dout[i] <= cart_d_in[i];
                    k[i] <= k[i] + 1;
                end else if (req_rd[i] || req_wr[i]) begin
                    k[i] <= 1;
                    op_rd[i] <= req_rd[i];
                    m_a[i] <= addr[i];
                    if (!req_rd[i]) m_dw[i] <= din[i];
`ifdef CART_CLK_SYNC_EN
                    m_div[i] <= 0;
`endif
                end else begin
                    k[i] <= 0;
                end
            end
        end
        if (rst) m_valid <= 1'b1;
    end

    always @(negedge clk_8m) begin
        if (m_valid) begin
            for (int i = 0; i < 2; i++) begin
                chk("ncs",     i, 32'(ncs[i]),  32'(!f_acc(i)));
                chk("nrd",     i, 32'(nrd[i]),  32'(!(f_acc(i) && op_rd[i])));
                chk("nwr",     i, 32'(nwr[i]),  32'(!f_wr_strobe(i)));
                chk("busdir",  i, 32'(bdir[i]), 32'(f_acc(i) && op_rd[i]));
                chk("ack",     i, 32'(ack[i]),  32'(k[i] == f_n(i) + 1));
                chk("busy",    i, 32'(busy[i]), 32'(f_acc(i) || req_rd[i] || req_wr[i]));
                chk("dout",    i, 32'(dout[i]), 32'(m_dout[i]));
                chk("cart_a",  i, 32'(cart_a[i]), 32'(m_a[i]));
                chk("cart_do", i, 32'(cart_d_out[i]), 32'(m_dw[i]));
                chk("cart_clk", i, 32'(cclk[i]), 32'(m_div[i] >= 4));
            end
        end
    end

    // Observes cycles 1..12 after an accept on DUT0 (caller is just past the accept edge).
    task automatic observe0(output int ack_cyc, output int nacks, output int ncs_low,
                            output int nrd_low, output int nwr_low, output int nwr_first,
                            output logic [12:0] clkb);
        ack_cyc = 0; nacks = 0; ncs_low = 0; nrd_low = 0; nwr_low = 0; nwr_first = 0; clkb = '0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk_8m);
            if (ack[0]) begin nacks++; if (ack_cyc == 0) ack_cyc = c; end
            if (!ncs[0]) ncs_low++;
            if (!nrd[0]) nrd_low++;
            if (!nwr[0]) begin nwr_low++; if (nwr_first == 0) nwr_first = c; end
            clkb[c] = cclk[0];
        end
    endtask

    task automatic access0(input bit rd, input bit wr, input logic [15:0] a, input logic [7:0] d,
                           output int ack_cyc, output int nacks, output int ncs_low,
                           output int nrd_low, output int nwr_low, output int nwr_first,
                           output logic [12:0] clkb);
        @(posedge clk_8m); #2;
        req_rd[0] = rd; req_wr[0] = wr; addr[0] = a; din[0] = d;
        @(posedge clk_8m); #2;
        req_rd[0] = 1'b0; req_wr[0] = 1'b0;
        observe0(ack_cyc, nacks, ncs_low, nrd_low, nwr_low, nwr_first, clkb);
    endtask

    initial begin
        int ac, na, nl, rl, wl, wf;
        logic [12:0] cb;
        logic [18:0] nb, ab;
        for (int i = 0; i < 2; i++) begin
            req_rd[i] = 1'b0; req_wr[i] = 1'b0; addr[i] = '0; din[i] = '0; cart_d_in[i] = '0;
        end
        repeat (3) @(posedge clk_8m);
        @(negedge clk_8m);
        chk("rst_dout", 0, 32'(dout[0]), 32'h0000_00FF);
        chk("rst_ncs",  0, 32'(ncs[0]),  32'h1);
        chk("rst_ack",  0, 32'(ack[0]),  32'h0);
        @(posedge clk_8m); #2;
        rst = 1'b0;

        // Read 0x4000, cart drives 0x5A.
        cart_d_in[0] = 8'h5A;
        access0(1'b1, 1'b0, 16'h4000, 8'h00, ac, na, nl, rl, wl, wf, cb);
        chk("rd_ack_cyc", 0, 32'(ac), 32'd5);
        chk("rd_nacks",   0, 32'(na), 32'd1);
        chk("rd_ncs_len", 0, 32'(nl), 32'd4);
        chk("rd_nrd_len", 0, 32'(rl), 32'd4);
        chk("rd_nwr_len", 0, 32'(wl), 32'd0);
        chk("rd_dout",    0, 32'(dout[0]), 32'h5A);
        chk("rd_cart_a",  0, 32'(cart_a[0]), 32'h4000);
`ifdef CART_CLK_SYNC_EN
        chk("phi_sync", 0, 32'(cb[8:1]), 32'hF0);
`else
        chk("phi_duty", 0, 32'($countones(cb[8:1])), 32'd4);
`endif

        // Write 0x03 to 0x2000.
        cart_d_in[0] = 8'hC3;
        access0(1'b0, 1'b1, 16'h2000, 8'h03, ac, na, nl, rl, wl, wf, cb);
        chk("wr_ack_cyc",   0, 32'(ac), 32'd5);
        chk("wr_ncs_len",   0, 32'(nl), 32'd4);
        chk("wr_nwr_len",   0, 32'(wl), 32'd2);
        chk("wr_nwr_first", 0, 32'(wf), 32'd2);
        chk("wr_cart_do",   0, 32'(cart_d_out[0]), 32'h03);
        chk("wr_cart_a",    0, 32'(cart_a[0]), 32'h2000);
        chk("wr_dout_kept", 0, 32'(dout[0]), 32'h5A);

        // Read and write together: read wins, one ack.
        cart_d_in[0] = 8'h99;
        access0(1'b1, 1'b1, 16'h0100, 8'hEE, ac, na, nl, rl, wl, wf, cb);
        chk("rw_nacks",   0, 32'(na), 32'd1);
        chk("rw_nwr_len", 0, 32'(wl), 32'd0);
        chk("rw_dout",    0, 32'(dout[0]), 32'h99);
        chk("rw_cart_do", 0, 32'(cart_d_out[0]), 32'h03);

        // Reset during cycle 2 of a write, then a read right after reset drops.
        @(posedge clk_8m); #2;
        req_wr[0] = 1'b1; addr[0] = 16'h3000; din[0] = 8'h77;
        @(posedge clk_8m); #2;
        req_wr[0] = 1'b0;
        @(posedge clk_8m); #2;
        rst = 1'b1;
        @(negedge clk_8m);
        chk("mid_nwr", 0, 32'(nwr[0]), 32'h0);
        @(posedge clk_8m); #2;
        rst = 1'b0; req_rd[0] = 1'b1; addr[0] = 16'h4001; cart_d_in[0] = 8'h3C;
        @(negedge clk_8m);
        chk("rst_mid_ncs",  0, 32'(ncs[0]),  32'h1);
        chk("rst_mid_nwr",  0, 32'(nwr[0]),  32'h1);
        chk("rst_mid_dout", 0, 32'(dout[0]), 32'hFF);
        chk("rst_mid_ack",  0, 32'(ack[0]),  32'h0);
        @(posedge clk_8m); #2;
        req_rd[0] = 1'b0;
        observe0(ac, na, nl, rl, wl, wf, cb);
        chk("post_rst_ack_cyc", 0, 32'(ac), 32'd5);
        chk("post_rst_nacks",   0, 32'(na), 32'd1);
        chk("post_rst_dout",    0, 32'(dout[0]), 32'h3C);

        // Back-to-back reads on DUT1 (N=7): request held through the first ack cycle.
        nb = '0; ab = '0;
        @(posedge clk_8m); #2;
        req_rd[1] = 1'b1; addr[1] = 16'h1234; cart_d_in[1] = 8'h11;
        @(posedge clk_8m); #2;
        for (int c = 1; c <= 18; c++) begin
            @(negedge clk_8m);
            nb[c] = ncs[1];
            ab[c] = ack[1];
            if (c == 8) begin
                chk("b2b_dout1", 1, 32'(dout[1]), 32'h11);
                #2 cart_d_in[1] = 8'h22;
            end
            if (c == 9) begin
                #2 req_rd[1] = 1'b0;
            end
            if (c == 16) chk("b2b_dout2", 1, 32'(dout[1]), 32'h22);
        end
        chk("b2b_ncs", 1, 32'(nb), 32'h70100);
        chk("b2b_ack", 1, 32'(ab), 32'h10100);

        repeat (4) @(posedge clk_8m);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
